// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two private result FIFOs (ALU side, LSB side)
// drained round-robin onto a single registered CDB broadcast.
module cdb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int ROB_WIDTH  = 4,
  parameter int FIFO_WIDTH = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,

  input  logic                  RS2ARB_en,
  input  logic [ROB_WIDTH-1:0]  RS2ARB_ROB_index,
  input  logic [31:0]           RS2ARB_value,
  input  logic [ADDR_WIDTH-1:0] RS2ARB_next_pc,
  output logic                  ARB2RS_full,

  input  logic                  LSB2ARB_en,
  input  logic [ROB_WIDTH-1:0]  LSB2ARB_ROB_index,
  input  logic [31:0]           LSB2ARB_value,
  output logic                  ARB2LSB_full,

  input  logic                  ROB2ARB_clear,

  output logic                  CDB_en,
  output logic [ROB_WIDTH-1:0]  CDB_ROB_index,
  output logic [31:0]           CDB_value,
  output logic [ADDR_WIDTH-1:0] CDB_next_pc,
  output logic                  CDB_src
);

  localparam int FIFO_DEPTH = 1 << FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0]   CNT_FULL = (FIFO_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_WIDTH:0]   CNT_ONE  = (FIFO_WIDTH+1)'(1);
  localparam logic [FIFO_WIDTH-1:0] PTR_ONE  = FIFO_WIDTH'(1);

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  // ALU FIFO storage
  logic [ROB_WIDTH-1:0]  alu_idx_mem [FIFO_DEPTH];
  logic [31:0]           alu_val_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] alu_pc_mem  [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] alu_head, alu_tail;
  logic [FIFO_WIDTH:0]   alu_cnt;

  // LSB FIFO storage
  logic [ROB_WIDTH-1:0]  lsb_idx_mem [FIFO_DEPTH];
  logic [31:0]           lsb_val_mem [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] lsb_head, lsb_tail;
  logic [FIFO_WIDTH:0]   lsb_cnt;

  logic last_grant;

  logic alu_valid, lsb_valid;
  logic grant_alu, grant_lsb;
  logic active;
  logic alu_push, lsb_push;
  logic alu_pop, lsb_pop;

  assign ARB2RS_full  = (alu_cnt == CNT_FULL);
  assign ARB2LSB_full = (lsb_cnt == CNT_FULL);

  assign alu_valid = (alu_cnt != '0);
  assign lsb_valid = (lsb_cnt != '0);

  // Round-robin: under contention the source that did not win last time goes.
  assign grant_alu = alu_valid && (!lsb_valid || (last_grant == SRC_LSB));
  assign grant_lsb = lsb_valid && (!alu_valid || (last_grant == SRC_ALU));

  assign active   = rdy_in && !ROB2ARB_clear;
  assign alu_push = active && RS2ARB_en  && !ARB2RS_full;
  assign lsb_push = active && LSB2ARB_en && !ARB2LSB_full;
  assign alu_pop  = active && grant_alu;
  assign lsb_pop  = active && grant_lsb;

  always_ff @(posedge clk_in) begin
    if (alu_push) begin
      alu_idx_mem[alu_tail] <= RS2ARB_ROB_index;
      alu_val_mem[alu_tail] <= RS2ARB_value;
      alu_pc_mem[alu_tail]  <= RS2ARB_next_pc;
    end
    if (lsb_push) begin
      lsb_idx_mem[lsb_tail] <= LSB2ARB_ROB_index;
      lsb_val_mem[lsb_tail] <= LSB2ARB_value;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      alu_head <= '0;
      alu_tail <= '0;
      alu_cnt  <= '0;
    end else if (rdy_in) begin
      if (ROB2ARB_clear) begin
        alu_head <= '0;
        alu_tail <= '0;
        alu_cnt  <= '0;
      end else begin
        if (alu_push) alu_tail <= alu_tail + PTR_ONE;
        if (alu_pop)  alu_head <= alu_head + PTR_ONE;
        unique case ({alu_push, alu_pop})
          2'b10:   alu_cnt <= alu_cnt + CNT_ONE;
          2'b01:   alu_cnt <= alu_cnt - CNT_ONE;
          default: alu_cnt <= alu_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lsb_head <= '0;
      lsb_tail <= '0;
      lsb_cnt  <= '0;
    end else if (rdy_in) begin
      if (ROB2ARB_clear) begin
        lsb_head <= '0;
        lsb_tail <= '0;
        lsb_cnt  <= '0;
      end else begin
        if (lsb_push) lsb_tail <= lsb_tail + PTR_ONE;
        if (lsb_pop)  lsb_head <= lsb_head + PTR_ONE;
        unique case ({lsb_push, lsb_pop})
          2'b10:   lsb_cnt <= lsb_cnt + CNT_ONE;
          2'b01:   lsb_cnt <= lsb_cnt - CNT_ONE;
          default: lsb_cnt <= lsb_cnt;
        endcase
      end
    end
  end

  // Broadcast register; data holds when nothing is granted.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      CDB_en        <= 1'b0;
      CDB_ROB_index <= '0;
      CDB_value     <= '0;
      CDB_next_pc   <= '0;
      CDB_src       <= SRC_ALU;
      last_grant    <= SRC_LSB;
    end else if (rdy_in) begin
      if (ROB2ARB_clear) begin
        CDB_en <= 1'b0;
      end else if (grant_alu) begin
        CDB_en        <= 1'b1;
        CDB_ROB_index <= alu_idx_mem[alu_head];
        CDB_value     <= alu_val_mem[alu_head];
        CDB_next_pc   <= alu_pc_mem[alu_head];
        CDB_src       <= SRC_ALU;
        last_grant    <= SRC_ALU;
      end else if (grant_lsb) begin
        CDB_en        <= 1'b1;
        CDB_ROB_index <= lsb_idx_mem[lsb_head];
        CDB_value     <= lsb_val_mem[lsb_head];
        CDB_next_pc   <= '0;
        CDB_src       <= SRC_LSB;
        last_grant    <= SRC_LSB;
      end else begin
        CDB_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: per-source expected queues filled as
// results are driven, popped by a monitor as the CDB broadcasts them.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        RS2ARB_en;
  logic [3:0]  RS2ARB_ROB_index;
  logic [31:0] RS2ARB_value;
  logic [31:0] RS2ARB_next_pc;
  logic        ARB2RS_full;
  logic        LSB2ARB_en;
  logic [3:0]  LSB2ARB_ROB_index;
  logic [31:0] LSB2ARB_value;
  logic        ARB2LSB_full;
  logic        ROB2ARB_clear;
  logic        CDB_en;
  logic [3:0]  CDB_ROB_index;
  logic [31:0] CDB_value;
  logic [31:0] CDB_next_pc;
  logic        CDB_src;

  cdb_arbiter #(.ADDR_WIDTH(32), .ROB_WIDTH(4), .FIFO_WIDTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .RS2ARB_en(RS2ARB_en), .RS2ARB_ROB_index(RS2ARB_ROB_index),
    .RS2ARB_value(RS2ARB_value), .RS2ARB_next_pc(RS2ARB_next_pc),
    .ARB2RS_full(ARB2RS_full),
    .LSB2ARB_en(LSB2ARB_en), .LSB2ARB_ROB_index(LSB2ARB_ROB_index),
    .LSB2ARB_value(LSB2ARB_value), .ARB2LSB_full(ARB2LSB_full),
    .ROB2ARB_clear(ROB2ARB_clear),
    .CDB_en(CDB_en), .CDB_ROB_index(CDB_ROB_index), .CDB_value(CDB_value),
    .CDB_next_pc(CDB_next_pc), .CDB_src(CDB_src)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] val;
    logic [31:0] pc;
  } item_t;

  item_t exp_a[$];
  item_t exp_l[$];

  int n_checks = 0;
  int n_pass   = 0;
  int bcount   = 0;
  bit in_t3    = 0;
  bit saw_full_a = 0, saw_full_l = 0;
  bit prev_full_a = 0, prev_full_l = 0;
  logic last_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    RS2ARB_en = 0; RS2ARB_ROB_index = '0; RS2ARB_value = '0; RS2ARB_next_pc = '0;
    LSB2ARB_en = 0; LSB2ARB_ROB_index = '0; LSB2ARB_value = '0;
  endtask

  task automatic drive_alu(input logic [3:0] idx, input logic [31:0] val, input logic [31:0] pc);
    item_t e;
    RS2ARB_en = 1; RS2ARB_ROB_index = idx; RS2ARB_value = val; RS2ARB_next_pc = pc;
    e.idx = idx; e.val = val; e.pc = pc;
    exp_a.push_back(e);
  endtask

  task automatic drive_lsb(input logic [3:0] idx, input logic [31:0] val);
    item_t e;
    LSB2ARB_en = 1; LSB2ARB_ROB_index = idx; LSB2ARB_value = val;
    e.idx = idx; e.val = val; e.pc = '0;
    exp_l.push_back(e);
  endtask

  task automatic do_reset();
    rst_in = 1;
    exp_a.delete();
    exp_l.delete();
    tick();
    tick();
    rst_in = 0;
    tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && (exp_a.size() + exp_l.size()) != 0; i++) tick();
    check({tag, "_drain_left"}, 32'(exp_a.size() + exp_l.size()), 0);
  endtask

  always @(posedge clk_in) last_rdy <= rdy_in;

  // A new broadcast is present at a negedge when the previous edge was not paused.
  always @(negedge clk_in) begin
    item_t e;
    if (!rst_in) begin
      if (last_rdy && CDB_en) begin
        if (CDB_src == 1'b0) begin
          if (exp_a.size() == 0) check("alu_unexpected", 1, 0);
          else begin
            e = exp_a.pop_front();
            check("alu_idx", 32'(CDB_ROB_index), 32'(e.idx));
            check("alu_val", CDB_value, e.val);
            check("alu_pc", CDB_next_pc, e.pc);
          end
          if (prev_full_a) check("alu_full_drop", 32'(ARB2RS_full), 0);
        end else begin
          if (exp_l.size() == 0) check("lsb_unexpected", 1, 0);
          else begin
            e = exp_l.pop_front();
            check("lsb_idx", 32'(CDB_ROB_index), 32'(e.idx));
            check("lsb_val", CDB_value, e.val);
            check("lsb_pc", CDB_next_pc, 0);
          end
          if (prev_full_l) check("lsb_full_drop", 32'(ARB2LSB_full), 0);
        end
        if (in_t3) begin
          check("t3_alternate", 32'(CDB_src), 32'(bcount[0]));
          bcount++;
        end
      end
      prev_full_a = ARB2RS_full;
      prev_full_l = ARB2LSB_full;
      if (ARB2RS_full)  saw_full_a = 1;
      if (ARB2LSB_full) saw_full_l = 1;
    end else begin
      prev_full_a = 0;
      prev_full_l = 0;
    end
  end

  initial begin
    int ia, il;
    rst_in = 1; rdy_in = 1; ROB2ARB_clear = 0;
    idle();
    do_reset();

    // Reset state
    check("rst_cdb_en", 32'(CDB_en), 0);
    check("rst_cdb_idx", 32'(CDB_ROB_index), 0);
    check("rst_cdb_val", CDB_value, 0);
    check("rst_cdb_pc", CDB_next_pc, 0);
    check("rst_cdb_src", 32'(CDB_src), 0);
    check("rst_alu_full", 32'(ARB2RS_full), 0);
    check("rst_lsb_full", 32'(ARB2LSB_full), 0);

    // Single ALU result, minimum latency
    drive_alu(4'd3, 32'h11, 32'h104);
    tick();
    idle();
    check("t1_en_after_e0", 32'(CDB_en), 0);
    tick();
    check("t1_en_after_e1", 32'(CDB_en), 1);
    check("t1_src", 32'(CDB_src), 0);
    tick();
    check("t1_en_drops", 32'(CDB_en), 0);
    drain("t1");

    // Simultaneous ALU and LSB after reset: ALU first, back to back
    do_reset();
    drive_alu(4'd1, 32'h21, 32'h200);
    drive_lsb(4'd2, 32'h22);
    tick();
    idle();
    tick();
    check("t2_first_en", 32'(CDB_en), 1);
    check("t2_first_src", 32'(CDB_src), 0);
    tick();
    check("t2_second_en", 32'(CDB_en), 1);
    check("t2_second_src", 32'(CDB_src), 1);
    drain("t2");

    // Both sources pushing continuously until each FIFO fills; a push while
    // full carries junk that must never appear on the bus.
    do_reset();
    in_t3 = 1; bcount = 0; saw_full_a = 0; saw_full_l = 0;
    ia = 0; il = 0;
    for (int cyc = 0; cyc < 200 && (ia < 8 || il < 8); cyc++) begin
      idle();
      if (ia < 8) begin
        if (ARB2RS_full) begin
          RS2ARB_en = 1; RS2ARB_ROB_index = 4'hf; RS2ARB_value = 32'hdead_0000;
        end else begin
          drive_alu(4'(ia), 32'h100 + 32'(ia), 32'h2000 + 32'(4 * ia));
          ia++;
        end
      end
      if (il < 8) begin
        if (ARB2LSB_full) begin
          LSB2ARB_en = 1; LSB2ARB_ROB_index = 4'hf; LSB2ARB_value = 32'hdead_1111;
        end else begin
          drive_lsb(4'(il + 4), 32'h5000 + 32'(il));
          il++;
        end
      end
      tick();
    end
    idle();
    check("t3_pushed", 32'(ia + il), 16);
    drain("t3");
    tick();
    in_t3 = 0;
    check("t3_bcasts", 32'(bcount), 16);
    check("t3_alu_full_seen", 32'(saw_full_a), 1);
    check("t3_lsb_full_seen", 32'(saw_full_l), 1);

    // Clear with queued results and a same-cycle LSB push
    do_reset();
    RS2ARB_en = 1; RS2ARB_ROB_index = 4'd5; RS2ARB_value = 32'h55; RS2ARB_next_pc = 32'h500;
    LSB2ARB_en = 1; LSB2ARB_ROB_index = 4'd6; LSB2ARB_value = 32'h66;
    tick();
    idle();
    ROB2ARB_clear = 1;
    LSB2ARB_en = 1; LSB2ARB_ROB_index = 4'd7; LSB2ARB_value = 32'h77;
    tick();
    idle();
    ROB2ARB_clear = 0;
    check("t4_en_after_clear", 32'(CDB_en), 0);
    check("t4_alu_full", 32'(ARB2RS_full), 0);
    check("t4_lsb_full", 32'(ARB2LSB_full), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_quiet", 32'(CDB_en), 0);
    end

    // Pause while a broadcast is on the bus and another result is queued
    do_reset();
    drive_alu(4'd8, 32'h88, 32'h800);
    drive_lsb(4'd9, 32'h99);
    tick();
    idle();
    tick();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_hold_en", 32'(CDB_en), 1);
      check("t5_hold_idx", 32'(CDB_ROB_index), 8);
      check("t5_hold_src", 32'(CDB_src), 0);
    end
    rdy_in = 1;
    tick();
    check("t5_resume_en", 32'(CDB_en), 1);
    check("t5_resume_idx", 32'(CDB_ROB_index), 9);
    check("t5_resume_src", 32'(CDB_src), 1);
    drain("t5");

    // Async reset mid-burst; the last grant before it was ALU
    do_reset();
    drive_alu(4'd1, 32'ha1, 32'h10);
    tick();
    drive_alu(4'd2, 32'ha2, 32'h14);
    tick();
    drive_alu(4'd3, 32'ha3, 32'h18);
    tick();
    idle();
    rst_in = 1;
    exp_a.delete();
    exp_l.delete();
    #1;
    check("t6_en_async", 32'(CDB_en), 0);
    check("t6_alu_full", 32'(ARB2RS_full), 0);
    tick();
    rst_in = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_empty_after_rst", 32'(CDB_en), 0);
    end
    drive_alu(4'd10, 32'hb0, 32'h30);
    drive_lsb(4'd11, 32'hb1);
    tick();
    idle();
    tick();
    check("t6_first_src", 32'(CDB_src), 0);
    check("t6_first_idx", 32'(CDB_ROB_index), 10);
    drain("t6");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
